// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-cycle multiply / restoring divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU run in RUN (Busy); MTHI/MTLO write HI/LO in a single cycle.
module hilo_muldiv_unit #(
   parameter logic [5:0] OP_MULT  = 6'd20,
   parameter logic [5:0] OP_MULTU = 6'd21,
   parameter logic [5:0] OP_DIV   = 6'd22,
   parameter logic [5:0] OP_DIVU  = 6'd23,
   parameter logic [5:0] OP_MTHI  = 6'd24,
   parameter logic [5:0] OP_MTLO  = 6'd25
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [5:0]  ALUCtrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] work;      // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] opnd;      // multiplicand or divisor magnitude
   logic [31:0] dividend;  // raw A, returned in HI on divide by zero
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;

   logic        accept;
   logic        is_mul_op;
   logic        is_div_op;
   logic        is_signed_op;
   logic        is_mt_op;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   logic [32:0] sum;
   logic [32:0] diff;
   logic [63:0] work_nxt;
   logic [63:0] prod;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] hi_res;
   logic [31:0] lo_res;

   // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      accept       = Start && (state != RUN);
      is_mul_op    = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);
      is_div_op    = (ALUCtrl == OP_DIV)  || (ALUCtrl == OP_DIVU);
      is_signed_op = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV);
      is_mt_op     = (ALUCtrl == OP_MTHI) || (ALUCtrl == OP_MTLO);
      a_mag        = (is_signed_op && A[31]) ? -A : A;
      b_mag        = (is_signed_op && B[31]) ? -B : B;
   end

   always_comb begin
      sum  = {1'b0, work[63:32]} + {1'b0, opnd};
      // Trial subtract of the shifted remainder; bit 32 set means it went negative.
      diff = {work[63:32], work[31]} - {1'b0, opnd};

      if (is_div)
         work_nxt = diff[32] ? {work[62:0], 1'b0} : {diff[31:0], work[30:0], 1'b1};
      else
         work_nxt = work[0] ? {sum, work[31:1]} : {1'b0, work[63:1]};

      prod  = neg_q ? -work_nxt : work_nxt;
      q_fix = neg_q ? -work_nxt[31:0]  : work_nxt[31:0];
      r_fix = neg_r ? -work_nxt[63:32] : work_nxt[63:32];

      hi_res = prod[63:32];
      lo_res = prod[31:0];
      if (is_div) begin
         if (div_zero) begin
            hi_res = dividend;
            lo_res = 32'hFFFF_FFFF;
         end else begin
            hi_res = r_fix;
            lo_res = q_fix;
         end
      end
   end

   // NOTE: the datapath registers (work, opnd, sign flags) are loaded on accept before use,
   // so only control state and the architectural HI/LO take the reset value.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
         Hi    <= 32'd0;
         Lo    <= 32'd0;
      end else begin
         case (state)
            RUN: begin
               work <= work_nxt;
               cnt  <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= DONE;
                  Hi    <= hi_res;
                  Lo    <= lo_res;
               end
            end
            default: begin
               state <= IDLE;
               if (accept) begin
                  if (is_mt_op) begin
                     if (ALUCtrl == OP_MTHI)
                        Hi <= A;
                     else
                        Lo <= A;
                  end else if (is_mul_op || is_div_op) begin
                     state    <= RUN;
                     cnt      <= 5'd0;
                     is_div   <= is_div_op;
                     work     <= {32'd0, a_mag};
                     opnd     <= b_mag;
                     dividend <= A;
                     div_zero <= (B == 32'd0);
                     neg_q    <= is_signed_op && (A[31] ^ B[31]);
                     neg_r    <= is_signed_op && A[31];
                  end
               end
            end
         endcase
      end
   end

   assign Busy = (state == RUN);
   assign Done = (state == DONE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO pushed at issue,
// popped and compared whenever Done is seen.
module tb_hilo_muldiv_unit;

   localparam logic [5:0] OP_MULT  = 6'd20;
   localparam logic [5:0] OP_MULTU = 6'd21;
   localparam logic [5:0] OP_DIV   = 6'd22;
   localparam logic [5:0] OP_DIVU  = 6'd23;
   localparam logic [5:0] OP_MTHI  = 6'd24;
   localparam logic [5:0] OP_MTLO  = 6'd25;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic [5:0]  ALUCtrl = 6'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        Busy;
   logic        Done;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb_q[$];
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   hilo_muldiv_unit dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .ALUCtrl(ALUCtrl), .A(A), .B(B),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp_v);
      end
   endtask

   function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     sa, sbv;
      logic [31:0] q, r;
      sa  = a;
      sbv = b;
      case (op)
         OP_MULT: begin
            p = longint'(sa) * longint'(sbv);
            return p;
         end
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sbv;
            r = sa % sbv;
            return {r, q};
         end
      endcase
   endfunction

   // Compare on the falling edge, away from the edge that updates the DUT.
   always @(negedge Clk) begin
      if (Done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check("hi", {32'd0, Hi}, {32'd0, e[63:32]});
            check("lo", {32'd0, Lo}, {32'd0, e[31:0]});
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
      logic [63:0] e;
      if (track) begin
         e = model(op, a, b);
         sb_q.push_back(e);
         model_hi = e[63:32];
         model_lo = e[31:0];
      end
      Start = 1'b1; ALUCtrl = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom;
   endtask

   task automatic wait_result(input int inject);
      int n = 0;
      int busy_cnt = 0;
      while (!Done && n < 100) begin
         busy_cnt += int'(Busy);
         if (n == inject) begin
            Start = 1'b1; ALUCtrl = OP_MTLO; A = 32'd5;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clk); #1;
         n++;
      end
      Start = 1'b0;
      check("done_seen", {63'd0, Done}, 64'd1);
      check("busy_len", 64'(busy_cnt), 64'd32);
   endtask

   task automatic settle();
      @(posedge Clk); #1;
      check("busy_after", {63'd0, Busy}, 64'd0);
      check("done_after", {63'd0, Done}, 64'd0);
   endtask

   task automatic move_to(input logic [5:0] op, input logic [31:0] a);
      Start = 1'b1; ALUCtrl = op; A = a;
      if (op == OP_MTHI) model_hi = a; else model_lo = a;
      @(posedge Clk); #1;
      Start = 1'b0;
      check("mt_hi", {32'd0, Hi}, {32'd0, model_hi});
      check("mt_lo", {32'd0, Lo}, {32'd0, model_lo});
      check("mt_busy", {63'd0, Busy}, 64'd0);
      check("mt_done", {63'd0, Done}, 64'd0);
   endtask

   initial begin
      int dones;
      logic [5:0]  op;
      logic [31:0] ra, rb;

      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      check("rst_hi", {32'd0, Hi}, 64'd0);
      check("rst_lo", {32'd0, Lo}, 64'd0);
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_done", {63'd0, Done}, 64'd0);

      launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_result(-1);
      settle();

      // Second op issued in the DONE cycle is accepted back-to-back.
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_result(-1);
      launch(OP_DIVU, 32'd100, 32'd7, 1'b1);
      wait_result(-1);
      settle();

      launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_result(-1); settle();
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_result(-1); settle();
      launch(OP_DIVU, 32'h0000_1234, 32'd0, 1'b1);        wait_result(-1); settle();
      launch(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);         wait_result(-1); settle();
      launch(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_result(-1); settle();

      // MTLO during RUN must be dropped; LO ends up holding the product.
      launch(OP_MULT, 32'd12345, 32'hFFFF_FFFE, 1'b1);
      wait_result(10);
      settle();

      move_to(OP_MTLO, 32'd5);
      move_to(OP_MTHI, 32'hCAFE_F00D);

      Start = 1'b1; ALUCtrl = 6'd3; A = 32'hDEAD_BEEF; B = 32'd1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("unk_busy", {63'd0, Busy}, 64'd0);
      check("unk_done", {63'd0, Done}, 64'd0);
      check("unk_hilo", {Hi, Lo}, {model_hi, model_lo});

      for (int i = 0; i < 8; i++) begin
         op = OP_MULT + 6'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i % 3 == 0) ra = -ra;
         launch(op, ra, rb, 1'b1);
         wait_result(-1);
      end
      settle();

      // Reset mid-divide: result discarded, registers cleared, no Done afterwards.
      launch(OP_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (14) @(posedge Clk);
      #1 Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      model_hi = 32'd0;
      model_lo = 32'd0;
      check("abort_hi", {32'd0, Hi}, 64'd0);
      check("abort_lo", {32'd0, Lo}, 64'd0);
      check("abort_busy", {63'd0, Busy}, 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         dones += int'(Done);
         @(posedge Clk); #1;
      end
      check("abort_no_done", 64'(dones), 64'd0);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO result registers, in the EX stage directly downstream of ALUControl. It consumes ALUCtrl codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO plus the two register operands. It runs 32-iteration shift-add multiply or restoring divide, and raises Busy so hazard logic can stall the pipeline. Hi/Lo feed the MFHI/MFLO forwarding path.

Parameters:
OP_MULT, 6'd20, ALUCtrl code for signed multiply
OP_MULTU, 6'd21, ALUCtrl code for unsigned multiply
OP_DIV, 6'd22, ALUCtrl code for signed divide
OP_DIVU, 6'd23, ALUCtrl code for unsigned divide
OP_MTHI, 6'd24, ALUCtrl code for move-to-HI
OP_MTLO, 6'd25, ALUCtrl code for move-to-LO

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  synchronous active-high reset
Start  input  1  request valid this cycle
ALUCtrl  input  6  operation code from ALUControl
A  input  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
B  input  32  rt operand (multiplier / divisor)
Hi  output  32  HI register
Lo  output  32  LO register
Busy  output  1  iterative op in progress; pipeline must stall
Done  output  1  one-cycle pulse when Hi/Lo take a mul/div result

Behaviour:
- Reset: Rst high at an edge -> state IDLE, Hi=0, Lo=0, Busy=0, Done=0, iteration counter=0. This applies in any state; an op in flight is aborted and no result is written.
- States: IDLE, RUN, DONE. Busy=1 only in RUN. Done=1 only in DONE. Both outputs are decoded from the registered state.
- Accept: Start sampled only in IDLE or DONE. Start with an ALUCtrl not among the six codes is ignored. Start in RUN is ignored, with no queueing.
- MTHI/MTLO accepted: Hi<=A or Lo<=A at the same edge. State -> IDLE. No Busy, no Done. The other register is unchanged.
- MULT/MULTU/DIV/DIVU accepted at edge T0:
  - Operands latched.
  - Signed ops latch magnitudes and record the result signs.
  - State -> RUN, counter=0.
- RUN: one iteration per cycle for 32 cycles (counter 0..31). At the edge where counter=31 completes, state -> DONE and the results are written to Hi/Lo.
  - Results are visible in the cycle after edge T0+32, with Done=1 that cycle.
  - Busy is high for exactly 32 cycles.
- DONE lasts one cycle, then IDLE. A new Start in DONE is accepted as in IDLE.
- Multiply: 64-bit product, Hi=product[63:32], Lo=product[31:0]. Signed result is two's-complement negated when the operand signs differ.
- Divide: Lo=quotient, Hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (B=0, DIV or DIVU): full 32 cycles still run. Result Lo=32'hFFFFFFFF, Hi=A.
- Signed overflow (DIV, A=32'h80000000, B=32'hFFFFFFFF): Lo=32'h80000000, Hi=0.
- Hi/Lo hold their value at all times except on writes defined above.
- Operand inputs may change while Busy; only the latched copies are used.

Test Plan:
- Reset, then MULT A=32'hFFFFFFFD (-3), B=7 -> Busy high 32 cycles. Done pulse at cycle 33 with Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB, then Busy=0, Done=0.
- MULTU A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001. DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF. DIV 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0.
- DIVU A=32'h1234, B=0 -> after 32 Busy cycles, Lo=32'hFFFFFFFF, Hi=32'h1234.
- MULT started, then Start with MTLO A=5 at cycle 10 of RUN -> ignored. Final Lo equals the product. MTLO A=5 issued in IDLE -> Lo=5 next cycle, Hi unchanged, Done stays 0.
- DIV started, Rst pulsed at cycle 15 -> Hi=Lo=0, Busy=0. No Done pulse follows. An unknown ALUCtrl=6'd3 with Start -> no state change.
